// File: rtl/and_kask.sv
// and_kask -- cascaded AND reduction / wide all-ones detector.
//
// A chain of 2-input AND stages reduces x to y. Every intermediate stage is
// exported as a tap, so chain[i] is the AND of x[0..i]. The result is also
// registered (y_q), and y_rise pulses on the 0->1 edge of y_q.
//
// Parameters:
//   LENGTH     width of x, legal range 2..64
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset (clears y_q, y_rise and the
//              optional zero-index registers)
//   x          operand vector [LENGTH-1:0]
//   y          combinational AND of all bits of x
//   chain      combinational cascade taps [LENGTH-1:0]
//   y_q        y registered on clk
//   y_rise     one-cycle pulse when y_q goes 0->1
//   zero_idx   (AND_KASK_ZERO_IDX_EN) registered index of lowest zero bit of x
//   zero_none  (AND_KASK_ZERO_IDX_EN) registered flag, x was all-ones
//
// Optional feature macro: AND_KASK_ZERO_IDX_EN
module and_kask #(
    parameter int LENGTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LENGTH-1:0] x,
    output logic              y,
    output logic [LENGTH-1:0] chain,
    output logic              y_q,
`ifdef AND_KASK_ZERO_IDX_EN
    output logic              y_rise,
    output logic [(LENGTH > 1 ? $clog2(LENGTH) : 1)-1:0] zero_idx,
    output logic              zero_none
`else
    output logic              y_rise
`endif
);

    generate
        if (LENGTH < 2) begin : g_bad_len
            $error("and_kask: LENGTH must be at least 2");
        end
    endgenerate

    // Explicit ripple chain: one 2-input AND per stage.
    assign chain[0] = x[0];
    generate
        for (genvar i = 1; i < LENGTH; i++) begin : g_stage
            assign chain[i] = chain[i-1] & x[i];
        end
    endgenerate

    assign y = chain[LENGTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= 1'b0;
            y_rise <= 1'b0;
        end else begin
            y_q    <= y;
            // Uses the pre-edge y_q, so this is high exactly on the edge where
            // y_q transitions 0->1.
            y_rise <= y & ~y_q;
        end
    end

`ifdef AND_KASK_ZERO_IDX_EN
    localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    // The first zero in the cascade marks the lowest zero bit of x: that
    // stage is 0 while its predecessor is still 1, so first_zero is one-hot
    // (or all-zero when x is all-ones) and can be OR-encoded.
    logic [LENGTH-1:0] first_zero;
    logic [IW-1:0]     idx_d;

    assign first_zero[0] = ~chain[0];
    generate
        for (genvar i = 1; i < LENGTH; i++) begin : g_fz
            assign first_zero[i] = chain[i-1] & ~chain[i];
        end
    endgenerate

    always_comb begin
        idx_d = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (first_zero[i]) idx_d = idx_d | IW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_idx  <= '0;
            zero_none <= 1'b0;
        end else begin
            zero_idx  <= idx_d;
            zero_none <= y;
        end
    end
`endif

endmodule

// File: tb/tb_and_kask.sv
// Directed self-checking bench for and_kask (LENGTH 10, plus 2 and 64 for
// the parameter sweep). Inputs change 2 time units after a rising edge;
// outputs are sampled 1 time unit after a rising edge or after the input
// change.
module tb_and_kask;

    logic        clk;
    logic        rst;
    logic [9:0]  x;
    logic        y;
    logic [9:0]  chain;
    logic        y_q;
    logic        y_rise;
`ifdef AND_KASK_ZERO_IDX_EN
    logic [3:0]  zero_idx;
    logic        zero_none;
`endif

    logic [1:0]  x2, chain2;
    logic        y2, yq2, yr2;
    logic [63:0] x64, chain64;
    logic        y64, yq64, yr64;
`ifdef AND_KASK_ZERO_IDX_EN
    logic [0:0]  zi2;
    logic        zn2;
    logic [5:0]  zi64;
    logic        zn64;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    and_kask #(.LENGTH(10)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .chain(chain), .y_q(y_q),
`ifdef AND_KASK_ZERO_IDX_EN
        .y_rise(y_rise), .zero_idx(zero_idx), .zero_none(zero_none)
`else
        .y_rise(y_rise)
`endif
    );

    and_kask #(.LENGTH(2)) dut2 (
        .clk(clk), .rst(rst), .x(x2), .y(y2), .chain(chain2), .y_q(yq2),
`ifdef AND_KASK_ZERO_IDX_EN
        .y_rise(yr2), .zero_idx(zi2), .zero_none(zn2)
`else
        .y_rise(yr2)
`endif
    );

    and_kask #(.LENGTH(64)) dut64 (
        .clk(clk), .rst(rst), .x(x64), .y(y64), .chain(chain64), .y_q(yq64),
`ifdef AND_KASK_ZERO_IDX_EN
        .y_rise(yr64), .zero_idx(zi64), .zero_none(zn64)
`else
        .y_rise(yr64)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        ey, eq, er;
        logic [9:0]  xv;
        logic [63:0] e64;
        int          rises;

        // ---- reset with x all-ones ----
        rst = 1'b1;
        x = 10'd1023; x2 = '1; x64 = '1;
        edge_settle();
        edge_settle();
        chk("rst_y", y, 1);
        chk("rst_yq", y_q, 0);
        chk("rst_yrise", y_rise, 0);
        @(negedge clk);
        rst = 1'b0;
        edge_settle();
        chk("rel_yq", y_q, 1);
        chk("rel_yrise", y_rise, 1);
        edge_settle();
        chk("rel_yq2", y_q, 1);
        chk("rel_yrise_clr", y_rise, 0);

        // ---- taps ----
        #1 x = 10'b1111101111;
        #1;
        chk("tap_a_chain", chain, 10'b0000001111);
        chk("tap_a_y", y, 0);
`ifdef AND_KASK_ZERO_IDX_EN
        edge_settle();
        chk("zidx_a", zero_idx, 4);
        chk("znone_a", zero_none, 0);
`endif
        #1 x = 10'b0000000001;
        #1;
        chk("tap_b_chain", chain, 10'b0000000001);
        #1 x = 10'd0;
        #1;
        chk("tap_zero_chain", chain, 0);
        #1 x = 10'd1023;
        #1;
        chk("tap_ones_chain", chain, 10'h3ff);
        chk("tap_ones_y", y, 1);
`ifdef AND_KASK_ZERO_IDX_EN
        edge_settle();
        chk("zidx_ones", zero_idx, 0);
        chk("znone_ones", zero_none, 1);
`endif

        // ---- increment sweep through two wraps ----
        edge_settle();
        #1 x = 10'd1000;
        edge_settle();
        eq = 1'b0;
        chk("sw_pre_yq", y_q, 0);
        xv = 10'd1000;
        rises = 0;
        for (int n = 0; n < 1060; n++) begin
            #1 x = xv;
            #1;
            ey = (xv == 10'd1023);
            chk("sw_y", y, ey);
            edge_settle();
            er = ey & ~eq;
            eq = ey;
            chk("sw_yq", y_q, eq);
            chk("sw_yrise", y_rise, er);
            if (y_rise) rises++;
            xv = xv + 10'd1;
        end
        chk("sw_rise_count", rises, 2);

        // ---- async reset mid-operation ----
        #1 x = 10'd1023;
        edge_settle();
        edge_settle();
        chk("ar_pre_yq", y_q, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_yq", y_q, 0);
        chk("ar_yrise", y_rise, 0);
        chk("ar_y", y, 1);
        @(negedge clk);
        rst = 1'b0;
        edge_settle();
        chk("ar_rel_yq", y_q, 1);
        chk("ar_rel_yrise", y_rise, 1);

        // ---- parameter sweep: LENGTH 2 and 64 ----
        x2 = '1; x64 = '1;
        #1;
        chk("l2_ones_y", y2, 1);
        chk("l2_ones_chain", chain2, 2'b11);
        chk("l64_ones_y", y64, 1);
        chk("l64_ones_chain", chain64, 64'hffff_ffff_ffff_ffff);
        for (int k = 0; k < 2; k++) begin
            x2 = '1;
            x2[k] = 1'b0;
            #1;
            chk("l2_y", y2, 0);
            chk("l2_chain", chain2, (k == 0) ? 64'd0 : 64'd1);
        end
        for (int k = 0; k < 64; k++) begin
            x64 = '1;
            x64[k] = 1'b0;
            e64 = '0;
            for (int j = 0; j < k; j++) e64[j] = 1'b1;
            #1;
            chk("l64_y", y64, 0);
            chk("l64_chain", chain64, e64);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/and_kask.md
Name: and_kask

Overview:
- Parameterised cascaded AND reduction. A chain of 2-input AND stages reduces the LENGTH-bit input vector `x` to a single bit `y`.
- Also provides:
  - the per-stage cascade taps,
  - a registered copy of the result,
  - a rising-edge pulse on the registered result.
- Used as a wide all-ones detector, e.g. counter terminal-count detection.

Parameters:
- LENGTH, 10, width of input vector `x`; legal range 2..64.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- x  input  LENGTH  operand vector; may change at any time.
- y  output  1  combinational AND of all bits of `x`.
- chain  output  LENGTH  combinational cascade taps; `chain[i]` = AND of `x[0..i]`.
- y_q  output  1  `y` registered on `clk`.
- y_rise  output  1  one-cycle pulse when `y_q` goes from 0 to 1.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Cascade structure:
  - `chain[0]` = `x[0]`.
  - `chain[i]` = `chain[i-1]` & `x[i]` for i = 1..LENGTH-1.
  - `y` = `chain[LENGTH-1]`.
  - Must be built as an explicit chain, one 2-input AND per stage (generate loop), not a reduction operator.
- `y` and `chain` are purely combinational: no latency, valid one propagation delay after `x` changes, unaffected by `rst`.
- `y_q`:
  - Samples `y` on every rising `clk` edge, one-cycle latency.
  - `rst` asserted forces `y_q` = 0 immediately (asynchronous).
  - Holds 0 while `rst` is high.
- `y_rise`:
  - Registered; set to 1 for exactly one cycle on the edge where `y_q` changes 0→1 (internally: `y` & ~`y_q` sampled on the edge).
  - Cleared on the following edge unless the condition repeats.
  - Reset value 0.
  - After reset release, if `x` is already all-ones, the first edge sets `y_q` = 1 and `y_rise` = 1.
- Boundary conditions:
  - `x` all-ones: `y` = 1 and every `chain` bit = 1.
  - `x` = 0: all taps 0.
  - Lowest zero bit at position k: `chain[k..LENGTH-1]` = 0 and `chain[0..k-1]` = 1.
  - Glitches on `x` between clock edges affect only `y`/`chain`; registers see the value present at the edge.
  - Reset mid-operation clears `y_q` and `y_rise` immediately; behaviour resumes on the first edge after deassertion.
- Widths: no arithmetic. LENGTH below 2 is rejected at elaboration (generate-time `$error`).

Optional Feature:
- Macro: AND_KASK_ZERO_IDX_EN.
- Defined: adds two registered outputs.
  - `zero_idx` [$clog2(LENGTH)-1:0]: index of the lowest zero bit of `x`, computed from the cascade as the first i with `chain[i]` = 0.
  - `zero_none` (1 bit): 1 when `x` is all-ones; `zero_idx` = 0 in that case.
  - Same one-cycle latency as `y_q`; reset values `zero_idx` = 0, `zero_none` = 0.
- Not defined: these ports and their logic are absent; the rest of the behaviour is unchanged.

Test Plan:
- Reset: `rst` = 1 with `x` = 1023 → `y` = 1 combinationally, `y_q` = 0, `y_rise` = 0; release `rst` → next edge `y_q` = 1, `y_rise` = 1; following edge `y_rise` = 0.
- Increment sweep (LENGTH = 10): `x` starts at 1000, +1 each posedge → `y` = 0 for 1000..1022, `y` = 1 only at 1023, 0 again at 0 after wrap; `y_q` lags `y` by one cycle; exactly one `y_rise` pulse per wrap period.
- Taps: `x` = 10'b1111101111 → `chain` = 10'b0000001111, `y` = 0; `x` = 10'b0000000001 → `chain` = 10'b0000000001.
- Async reset mid-operation: `x` = 1023 held, assert `rst` between edges → `y_q` drops to 0 without a clock edge; deassert → `y_q` returns to 1 on next edge with a `y_rise` pulse.
- Zero index (with AND_KASK_ZERO_IDX_EN): `x` = 10'b1111101111 → next edge `zero_idx` = 4, `zero_none` = 0; `x` = 1023 → `zero_idx` = 0, `zero_none` = 1.
- Parameter sweep: LENGTH = 2 and 64, `x` all-ones vs. one zero at each position → `y` correct and the `chain` boundary at the lowest zero bit.
